// File: rtl/goertzel_tone_decider.sv
// ---------------------------------------------------------------------------
// goertzel_tone_decider
//
// Turns per-frame Goertzel tone magnitudes (G0 = space, G1 = mark) into a
// debounced binary FSK symbol stream with carrier detect. It makes one
// decision per frame, using a carrier threshold, a hysteresis margin and an
// IDLE/ACQUIRE/LOCKED state machine.
//
// Pipeline:
//   stage 1 : the edge that samples G_READY=1 latches G0/G1 and raises f_vld_q
//   stage 2 : the next edge classifies the frame and updates the outputs
//   Back-to-back G_READY strobes are fully pipelined.
//
// Ports:
//   sys_clk    in   1   system clock
//   sys_rst    in   1   synchronous active-high reset
//   G0         in  16   space-tone magnitude, valid with G_READY
//   G1         in  16   mark-tone magnitude, valid with G_READY
//   G_READY    in   1   one-cycle frame strobe
//   bit_out    out  1   current decided symbol (1 = mark)
//   bit_valid  out  1   one-cycle pulse per decided symbol
//   bit_ambig  out  1   with bit_valid: frame was ambiguous, bit_out held
//   carrier    out  1   high while LOCKED
//   state_dbg  out  2   0 = IDLE, 1 = ACQUIRE, 2 = LOCKED
//   mag_diff   out 17   signed g1 - g0 of the last frame (only when the
//                       TONE_DIFF_OUT_EN macro is defined)
// ---------------------------------------------------------------------------
module goertzel_tone_decider #(
    parameter logic [15:0] CARRIER_THRESH = 16'd2048,
    parameter logic [15:0] HYST           = 16'd256,
    parameter int unsigned CONFIRM        = 3,   // 2..15
    parameter int unsigned LOSS_COUNT     = 4    // 1..15
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] G0,
    input  logic [15:0] G1,
    input  logic        G_READY,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        bit_ambig,
    output logic        carrier,
    output logic [1:0]  state_dbg
`ifdef TONE_DIFF_OUT_EN
    ,
    output logic signed [16:0] mag_diff
`endif
);

    localparam logic [3:0] CONFIRM_C = 4'(CONFIRM);
    localparam logic [3:0] LOSS_C    = 4'(LOSS_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] g0_q;
    logic [15:0] g1_q;
    logic        f_vld_q;
    logic        cand_q;
    logic [3:0]  cnt_q;
    logic [3:0]  miss_q;
    logic        bit_out_q;
    logic        bit_valid_q;
    logic        bit_ambig_q;
    logic        carrier_q;

    // Frame classification of the latched magnitudes.
    logic        above_d;
    logic        raw_d;
    logic        ambig_d;
    logic [16:0] g0_ext_d;
    logic [16:0] g1_ext_d;
    logic [3:0]  cnt_inc_d;
    logic [3:0]  miss_inc_d;

    always_comb begin
        g0_ext_d = {1'b0, g0_q};
        g1_ext_d = {1'b0, g1_q};
        // max(g0,g1) >= T is the same as either one reaching T.
        above_d  = (g0_q >= CARRIER_THRESH) || (g1_q >= CARRIER_THRESH);
        raw_d    = 1'b0;
        ambig_d  = 1'b1;
        // 17-bit sums so a magnitude near full scale plus HYST cannot wrap.
        if (g1_ext_d > g0_ext_d + {1'b0, HYST}) begin
            raw_d   = 1'b1;
            ambig_d = 1'b0;
        end else if (g0_ext_d > g1_ext_d + {1'b0, HYST}) begin
            raw_d   = 1'b0;
            ambig_d = 1'b0;
        end
        cnt_inc_d  = (cnt_q  == 4'hF) ? cnt_q  : cnt_q  + 4'd1;
        miss_inc_d = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
    end

    // Stage 1: capture magnitudes on the strobe.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            g0_q    <= 16'd0;
            g1_q    <= 16'd0;
            f_vld_q <= 1'b0;
        end else begin
            f_vld_q <= G_READY;
            if (G_READY) begin
                g0_q <= G0;
                g1_q <= G1;
            end
        end
    end

    // Stage 2: lock/loss state machine with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cand_q      <= 1'b0;
            cnt_q       <= 4'd0;
            miss_q      <= 4'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_ambig_q <= 1'b0;
            carrier_q   <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
            bit_ambig_q <= 1'b0;
            if (f_vld_q) begin
                case (state_q)
                    IDLE: begin
                        if (above_d && !ambig_d) begin
                            state_q <= ACQUIRE;
                            cand_q  <= raw_d;
                            cnt_q   <= 4'd1;
                        end
                    end
                    ACQUIRE: begin
                        if (!above_d) begin
                            state_q <= IDLE;
                            cnt_q   <= 4'd0;
                        end else if (ambig_d) begin
                            cnt_q <= 4'd0;
                        end else if (raw_d == cand_q) begin
                            cnt_q <= cnt_inc_d;
                            if (cnt_inc_d >= CONFIRM_C) begin
                                state_q     <= LOCKED;
                                carrier_q   <= 1'b1;
                                bit_out_q   <= cand_q;
                                bit_valid_q <= 1'b1;
                                miss_q      <= 4'd0;
                            end
                        end else begin
                            // A new candidate restarts the count at 1;
                            // CONFIRM >= 2 so this never locks directly.
                            cand_q <= raw_d;
                            cnt_q  <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (above_d) begin
                            miss_q      <= 4'd0;
                            bit_valid_q <= 1'b1;
                            if (ambig_d) begin
                                bit_ambig_q <= 1'b1;
                            end else begin
                                bit_out_q <= raw_d;
                            end
                        end else if (miss_inc_d >= LOSS_C) begin
                            state_q   <= IDLE;
                            carrier_q <= 1'b0;
                            miss_q    <= 4'd0;
                            cnt_q     <= 4'd0;
                        end else begin
                            miss_q <= miss_inc_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef TONE_DIFF_OUT_EN
    logic signed [16:0] mag_diff_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mag_diff_q <= 17'sd0;
        end else if (f_vld_q) begin
            mag_diff_q <= $signed(g1_ext_d - g0_ext_d);
        end
    end

    assign mag_diff = mag_diff_q;
`endif

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign bit_ambig = bit_ambig_q;
    assign carrier   = carrier_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_goertzel_tone_decider.sv
// ---------------------------------------------------------------------------
// Self-checking bench for goertzel_tone_decider. It runs directed scenarios
// and then randomized frames. A frame-level behavioural model predicts the
// outputs at the stage-2 edge of every frame. Define TONE_DIFF_OUT_EN to
// also check mag_diff.
// ---------------------------------------------------------------------------
module tb_goertzel_tone_decider;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] G0 = 16'd0;
    logic [15:0] G1 = 16'd0;
    logic        G_READY = 1'b0;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ambig;
    logic        carrier;
    logic [1:0]  state_dbg;
`ifdef TONE_DIFF_OUT_EN
    logic signed [16:0] mag_diff;
`endif

    int tests = 0;
    int fails = 0;

    goertzel_tone_decider dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .G0        (G0),
        .G1        (G1),
        .G_READY   (G_READY),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ambig (bit_ambig),
        .carrier   (carrier),
        .state_dbg (state_dbg)
`ifdef TONE_DIFF_OUT_EN
        ,
        .mag_diff  (mag_diff)
`endif
    );

    always #21 sys_clk = ~sys_clk;

    // ---------------- behavioural model (one call per frame) ----------------
    localparam int THRESH = 2048;
    localparam int HYSTV  = 256;
    localparam int CONF   = 3;
    localparam int LOSS   = 4;

    int m_state, m_cand, m_cnt, m_miss, m_bit, m_carrier, m_valid, m_ambig, m_diff;

    task automatic model_reset();
        m_state = 0; m_cand = 0; m_cnt = 0; m_miss = 0;
        m_bit = 0; m_carrier = 0; m_valid = 0; m_ambig = 0; m_diff = 0;
    endtask

    task automatic model_frame(input int g0, input int g1);
        bit above;
        bit amb;
        int raw;
        above = ((g0 > g1) ? g0 : g1) >= THRESH;
        amb = 1'b0;
        raw = 0;
        if (g1 > g0 + HYSTV) raw = 1;
        else if (g0 > g1 + HYSTV) raw = 0;
        else amb = 1'b1;
        m_diff  = g1 - g0;
        m_valid = 0;
        m_ambig = 0;
        if (m_state == 0) begin
            if (above && !amb) begin
                m_state = 1; m_cand = raw; m_cnt = 1;
            end
        end else if (m_state == 1) begin
            if (!above) begin
                m_state = 0; m_cnt = 0;
            end else if (amb) begin
                m_cnt = 0;
            end else if (raw == m_cand) begin
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            end else begin
                m_cand = raw; m_cnt = 1;
            end
            if (m_state == 1 && m_cnt >= CONF) begin
                m_state = 2; m_carrier = 1; m_bit = m_cand; m_valid = 1; m_miss = 0;
            end
        end else begin
            if (above) begin
                m_miss = 0; m_valid = 1;
                if (amb) m_ambig = 1;
                else m_bit = raw;
            end else begin
                m_miss = (m_miss < 15) ? m_miss + 1 : 15;
                if (m_miss >= LOSS) begin
                    m_state = 0; m_carrier = 0; m_miss = 0; m_cnt = 0;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   {31'd0, bit_valid}, 32'(m_valid));
        chk({tag, ".ambig"},   {31'd0, bit_ambig}, 32'(m_ambig));
        chk({tag, ".bit"},     {31'd0, bit_out},   32'(m_bit));
        chk({tag, ".carrier"}, {31'd0, carrier},   32'(m_carrier));
        chk({tag, ".state"},   {30'd0, state_dbg}, 32'(m_state));
`ifdef TONE_DIFF_OUT_EN
        chk({tag, ".diff"},    {15'd0, mag_diff},  {15'd0, 17'(m_diff)});
`endif
        $display("[TB] %s g0/g1 -> valid=%0b bit=%0b ambig=%0b carrier=%0b state=%0d",
                 tag, bit_valid, bit_out, bit_ambig, carrier, state_dbg);
    endtask

    // One isolated frame: strobe, check at the stage-2 edge, then make sure
    // bit_valid/bit_ambig return to 0 on the following edge.
    task automatic do_frame(input string tag, input int g0, input int g1);
        @(negedge sys_clk);
        G0 = 16'(g0); G1 = 16'(g1); G_READY = 1'b1;
        @(negedge sys_clk);
        G_READY = 1'b0;
        @(posedge sys_clk); #1;
        model_frame(g0, g1);
        check_all(tag);
        @(posedge sys_clk); #1;
        m_valid = 0; m_ambig = 0;
        chk({tag, ".after_valid"}, {31'd0, bit_valid}, 32'd0);
        chk({tag, ".after_ambig"}, {31'd0, bit_ambig}, 32'd0);
    endtask

    // Two frames on consecutive cycles.
    task automatic do_pair(input string tag, input int a0, input int a1, input int b0, input int b1);
        @(negedge sys_clk);
        G0 = 16'(a0); G1 = 16'(a1); G_READY = 1'b1;
        @(negedge sys_clk);
        G0 = 16'(b0); G1 = 16'(b1);
        @(posedge sys_clk); #1;
        model_frame(a0, a1);
        check_all({tag, ".a"});
        @(negedge sys_clk);
        G_READY = 1'b0;
        @(posedge sys_clk); #1;
        model_frame(b0, b1);
        check_all({tag, ".b"});
        @(posedge sys_clk); #1;
        chk({tag, ".after_valid"}, {31'd0, bit_valid}, 32'd0);
    endtask

    function automatic int clamp16(input int v);
        return (v > 65535) ? 65535 : ((v < 0) ? 0 : v);
    endfunction

    initial begin
        int g0, g1, kind;
        model_reset();

        // Reset with a strobe during reset; nothing may come out of it.
        sys_rst = 1'b1;
        @(negedge sys_clk);
        G0 = 16'd0; G1 = 16'd40000; G_READY = 1'b1;
        @(negedge sys_clk);
        G_READY = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        check_all("reset0");
        @(posedge sys_clk); #1;
        check_all("reset1");

        // Lock onto mark.
        do_frame("lock1", 500, 6000);
        chk("lock1.state_const", {30'd0, state_dbg}, 32'd1);
        do_frame("lock2", 500, 6000);
        do_frame("lock3", 500, 6000);

        // Hysteresis and boundaries while locked.
        do_frame("hyst_amb",  5000, 5200);
        do_frame("hyst_space", 5600, 5000);
        do_frame("edge_256",  2000, 2256);
        do_frame("edge_257",  2000, 2257);
        do_frame("thr_exact", 0, 2048);
        do_frame("equal_hi",  9000, 9000);

        // Three misses then a carrier frame: stay locked.
        do_frame("miss1", 100, 100);
        do_frame("miss2", 1791, 2047);
        do_frame("miss3", 100, 100);
        do_frame("recover", 500, 6000);
        // Four misses: carrier drops on the fourth.
        for (int i = 0; i < 4; i++) do_frame($sformatf("loss%0d", i), 100, 100);
        chk("loss.carrier_const", {31'd0, carrier}, 32'd0);

        // Acquire restart, locking on space on the fourth frame.
        do_frame("acq1", 0, 6000);
        do_frame("acq2", 6000, 0);
        do_frame("acq3", 6000, 0);
        do_frame("acq4", 6000, 0);
        chk("acq4.bit_const", {31'd0, bit_out}, 32'd0);

        // Back-to-back frames while locked.
        do_pair("pair", 500, 6000, 6000, 500);

        // Below-threshold frame in ACQUIRE returns to IDLE.
        for (int i = 0; i < 4; i++) do_frame($sformatf("drop%0d", i), 100, 100);
        do_frame("acq_enter", 0, 6000);
        do_frame("acq_below", 100, 100);
        do_frame("diff_frame", 1000, 300);
`ifdef TONE_DIFF_OUT_EN
        chk("diff.const", {15'd0, mag_diff}, {15'd0, 17'h1FD44});
`endif

        // Randomized frames, with occasional back-to-back pairs.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: begin g0 = int'($urandom_range(0, 3000));  g1 = clamp16(g0 + int'($urandom_range(200, 20000))); end
                1: begin g1 = int'($urandom_range(0, 3000));  g0 = clamp16(g1 + int'($urandom_range(200, 20000))); end
                2: begin g0 = int'($urandom_range(1500, 8000)); g1 = clamp16(g0 + int'($urandom_range(0, 600)) - 300); end
                3: begin g0 = int'($urandom_range(0, 2047)); g1 = int'($urandom_range(0, 2047)); end
                default: begin g0 = int'($urandom_range(0, 65535)); g1 = int'($urandom_range(0, 65535)); end
            endcase
            if ($urandom_range(0, 7) == 0)
                do_pair($sformatf("rnd%0d", n), g0, g1, g1, g0);
            else
                do_frame($sformatf("rnd%0d", n), g0, g1);
        end

        // Reset while a frame is in flight: no bit_valid afterwards.
        do_frame("pre_mid", 500, 6000);
        @(negedge sys_clk);
        G0 = 16'd500; G1 = 16'd6000; G_READY = 1'b1;
        @(negedge sys_clk);
        G_READY = 1'b0; sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        @(posedge sys_clk); #1;
        check_all("midrst0");
        @(posedge sys_clk); #1;
        check_all("midrst1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/goertzel_tone_decider.md
Name: goertzel_tone_decider

Overview:
- Downstream consumer of parallel_goertzel. Takes the two 16-bit tone magnitudes (G0 = space tone, G1 = mark tone) and the G_READY frame strobe, and produces a debounced binary FSK symbol stream with carrier detect.
- Output feeds the UART/bit-sync logic that follows it.
- Decision is made once per Goertzel frame, using a carrier threshold, a hysteresis margin and a lock/loss state machine.

Parameters:
- CARRIER_THRESH, 16'd2048: minimum max(G0,G1) for a frame to count as "carrier present".
- HYST, 16'd256: margin one magnitude must exceed the other by for an unambiguous decision.
- CONFIRM, 3: consecutive matching unambiguous carrier frames needed to lock. Legal range 2..15.
- LOSS_COUNT, 4: consecutive no-carrier frames in LOCKED that drop carrier. Legal range 1..15.

Ports:
- sys_clk  in  1  system clock, 24 MHz.
- sys_rst  in  1  synchronous, active-high reset.
- G0  in  16  space-tone magnitude, valid when G_READY=1.
- G1  in  16  mark-tone magnitude, valid when G_READY=1.
- G_READY  in  1  one-cycle frame strobe from parallel_goertzel.
- bit_out  out  1  current decided symbol (1 = mark).
- bit_valid  out  1  one-cycle pulse per decided symbol.
- bit_ambig  out  1  qualifies bit_valid: frame was ambiguous and bit_out was held.
- carrier  out  1  high while in LOCKED.
- state_dbg  out  2  FSM state: 0 = IDLE, 1 = ACQUIRE, 2 = LOCKED.

Behaviour:
- One clock, sys_clk. Reset is synchronous and active-high on sys_rst; all logic is posedge sys_clk.
- Reset values:
  - bit_out, bit_valid, bit_ambig, carrier all 0.
  - state_dbg = IDLE.
  - Internal counters and magnitude latches 0.
  - A G_READY coincident with sys_rst is discarded.
  - Reset mid-frame discards the in-flight frame; no bit_valid follows.
- Stage 1, at the edge sampling G_READY=1:
  - Latch G0/G1 into g0_r/g1_r.
  - Set an internal f_vld for one cycle.
- Stage 2, at the next edge with f_vld=1:
  - Evaluate the frame.
  - Outputs update at this edge. Latency is 2 edges from the G_READY sample edge to visible bit_valid.
  - Back-to-back G_READY on consecutive cycles is fully pipelined; no frame is dropped.
- Frame classification (all comparisons unsigned, 17-bit sums, no overflow):
  - above = max(g0_r,g1_r) >= CARRIER_THRESH.
  - raw = 1 if g1_r > g0_r + HYST.
  - raw = 0 if g0_r > g1_r + HYST.
  - Otherwise the frame is ambig.
  - Equal magnitudes are ambig.
- FSM:
  - IDLE:
    - above and not ambig: go to ACQUIRE, cand = raw, cnt = 1.
    - Otherwise stay.
    - No outputs.
  - ACQUIRE:
    - not above: go to IDLE, cnt = 0.
    - above and ambig: stay, cnt = 0.
    - above, raw == cand: cnt++.
    - above, raw != cand: cand = raw, cnt = 1.
    - When cnt reaches CONFIRM: go to LOCKED, carrier = 1, bit_out = cand, bit_valid pulse with bit_ambig = 0, miss = 0.
  - LOCKED:
    - above: miss = 0 and bit_valid pulses.
      - Not ambig: bit_out = raw, bit_ambig = 0.
      - Ambig: bit_out held, bit_ambig = 1.
    - not above: no bit_valid, miss++.
    - miss reaching LOSS_COUNT: go to IDLE, carrier = 0 at that same edge, bit_out held.
- Outside a bit_valid cycle, bit_ambig returns to 0.
- Counters saturate at 15 and never wrap.

Optional Feature:
- Macro: TONE_DIFF_OUT_EN.
- When defined:
  - Adds output port mag_diff, 17-bit signed, equal to g1_r − g0_r.
  - Registered at the stage-2 edge of every frame, including IDLE and no-carrier frames.
  - Reset value 0.
  - Intended for threshold tuning on the logic analyser header.
- When undefined: the port and its register do not exist. Decision behaviour is identical either way.

Test Plan:
- Reset check: hold sys_rst 3 cycles with a G_READY pulse (G0=0, G1=40000) during reset.
  -> All outputs 0, state_dbg = 0, no bit_valid after release.
- Lock: 3 frames G0=500, G1=6000.
  -> state_dbg goes 0→1→1→2.
  -> carrier=1 and bit_valid with bit_out=1 exactly 2 edges after the 3rd G_READY. No bit_valid on frames 1–2.
- Hysteresis: in LOCKED with bit_out=1, frame G0=5000, G1=5200.
  -> bit_valid=1, bit_ambig=1, bit_out stays 1.
  -> Next frame G0=5600, G1=5000 gives bit_valid with bit_out=0, bit_ambig=0.
- Carrier loss: in LOCKED, 4 frames G0=G1=100.
  -> No bit_valid. carrier falls at stage 2 of the 4th frame; state_dbg = 0.
  -> With only 3 such frames followed by one above frame, carrier stays 1 and miss resets.
- Acquire restart: frames (G1=6000,G0=0), (G0=6000,G1=0), (G0=6000,G1=0), (G0=6000,G1=0).
  -> Lock with bit_out=0 on the 4th frame, not before.
  -> A below-threshold frame in ACQUIRE returns to IDLE.
- Throughput/option: G_READY on 2 consecutive cycles while LOCKED.
  -> Two bit_valid pulses on consecutive cycles.
  -> With TONE_DIFF_OUT_EN defined, G0=1000, G1=300 gives mag_diff = −700.
